ahb_decode_mux: RTL

AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

---
 rtl/ahb_decode_mux_if.sv | 22 ++
 rtl/ahb_decode_mux.sv | 65 ++++++
 2 files changed

// File: rtl/ahb_decode_mux_if.sv
// ahb_decode_mux_if: master-side address/response signals plus per-slave select and response lanes
interface ahb_decode_mux_if;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic [3:0]        hsel;
    logic [3:0][31:0]  rdata_s;
    logic [3:0]        readyout;
    logic [3:0]        resp_s;
    logic [31:0]       hrdata;
    logic              hready;
    logic              hresp;

    modport slave (
        input  haddr, htrans, rdata_s, readyout, resp_s,
        output hsel, hrdata, hready, hresp
    );

    modport master (
        output haddr, htrans, rdata_s, readyout, resp_s,
        input  hsel, hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_decode_mux.sv
// ahb_decode_mux: AHB address decoder, data-phase response mux and default error slave
module ahb_decode_mux #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S3_BASE = 32'h4000_8000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_F000
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    ahb_decode_mux_if.slave bus,
    output logic [31:0]     err_addr,
    output logic [7:0]      err_cnt
);
    localparam logic [2:0] SEL_DEF = 3'd4;
    typedef enum logic [1:0] {DS_OK, DS_ERR1, DS_ERR2} ds_t;
    ds_t        state, state_nxt;
    logic [2:0] sel_dec, dsel;
    logic       ds_ready, ds_resp, err_req;

    always_comb
        sel_dec = ((bus.haddr & S0_MASK) == S0_BASE) ? 3'd0 :
                  ((bus.haddr & S1_MASK) == S1_BASE) ? 3'd1 :
                  ((bus.haddr & S2_MASK) == S2_BASE) ? 3'd2 :
                  ((bus.haddr & S3_MASK) == S3_BASE) ? 3'd3 : SEL_DEF;

    assign bus.hsel   = sel_dec[2] ? 4'b0000 : 4'b0001 << sel_dec[1:0];
    assign bus.hrdata = dsel[2] ? 32'h0 : bus.rdata_s[dsel[1:0]];
    assign bus.hready = dsel[2] ? ds_ready : bus.readyout[dsel[1:0]];
    assign bus.hresp  = dsel[2] ? ds_resp : bus.resp_s[dsel[1:0]];
    // an unmapped NONSEQ/SEQ accepted this edge starts a two-cycle ERROR response
    assign err_req    = bus.hready & sel_dec[2] & bus.htrans[1];

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn)
            dsel <= SEL_DEF;
        else if (bus.hready)
            dsel <= sel_dec;

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn)
            state <= DS_OK;
        else
            state <= state_nxt;

    always_comb
        state_nxt = (state == DS_ERR1) ? DS_ERR2 : (err_req ? DS_ERR1 : DS_OK);

    always_comb begin
        ds_ready = state != DS_ERR1;
        ds_resp  = state != DS_OK;
    end

    always_ff @(posedge HCLK or negedge HRESETn)
        if (!HRESETn) begin
            err_addr <= 32'h0;
            err_cnt  <= 8'h0;
        end else if (err_req) begin
            err_addr <= bus.haddr;
            err_cnt  <= err_cnt + {7'd0, err_cnt != 8'hFF};
        end
endmodule
